// File: rtl/npu_layer_seq_if.sv
// Host/layer-fsm facing signal bundle of the multi-layer sequencer.
// run is level-sampled only while idle; npu_start and seq_done are single-cycle pulses, fsm_done is a level.
interface npu_layer_seq_if #(
  parameter int CLOG2ML = 3,
  parameter int OPW     = 3,
  parameter int TO_W    = 16
);
  logic               prog_we;
  logic [CLOG2ML-1:0] prog_addr;
  logic [OPW-1:0]     prog_opcode;
  logic               run;
  logic [CLOG2ML:0]   nb_layers;
  logic [TO_W-1:0]    to_limit;
  logic               abort;
  logic               fsm_done;
  logic [OPW-1:0]     npu_opcode;
  logic               npu_rst;
  logic               npu_start;
  logic               bank_sel;
  logic [CLOG2ML-1:0] cur_layer;
  logic               busy;
  logic               seq_done;
  logic               err;
  logic [1:0]         err_code;
  logic [2:0]         dbg_state;

  modport master (
    output prog_we, prog_addr, prog_opcode, run, nb_layers, to_limit, abort, fsm_done,
    input  npu_opcode, npu_rst, npu_start, bank_sel, cur_layer, busy, seq_done, err, err_code,
           dbg_state
  );

  modport slave (
    input  prog_we, prog_addr, prog_opcode, run, nb_layers, to_limit, abort, fsm_done,
    output npu_opcode, npu_rst, npu_start, bank_sel, cur_layer, busy, seq_done, err, err_code,
           dbg_state
  );
endinterface

// File: rtl/npu_layer_seq.sv
// Runs a table of layer opcodes through the conv layer fsm, one layer at a time,
// swapping the ping-pong activation bank between layers.
module npu_layer_seq #(
  parameter int MAX_LAYERS = 8,
  parameter int CLOG2ML    = 3,
  parameter int OPW        = 3,
  parameter int TO_W       = 16
) (
  input logic           ck,
  input logic           rst,
  npu_layer_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_ARM, S_START, S_RUN, S_NEXT, S_FIN, S_HALT
  } state_t;

  localparam logic [CLOG2ML:0] MAX_NB = (CLOG2ML+1)'(MAX_LAYERS);

  state_t             state_q, state_d;
  logic [OPW-1:0]     table_q [MAX_LAYERS];
  logic [OPW-1:0]     opcode_q, opcode_d;
  logic               bank_q, bank_d;
  logic [CLOG2ML-1:0] layer_q, layer_d;
  logic [CLOG2ML:0]   nb_q, nb_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               done_q;
  logic               done_edge;
  logic               nb_ok;
  logic               last_layer;

  assign done_edge  = bus.fsm_done & ~done_q;
  assign nb_ok      = (bus.nb_layers != '0) && (bus.nb_layers <= MAX_NB);
  assign last_layer = ({1'b0, layer_q} == (nb_q - 1'b1));

  // The table is only writable while idle, so a running program never changes under it.
  always_ff @(posedge ck) begin
    if (state_q == S_IDLE && bus.prog_we) begin
      table_q[bus.prog_addr] <= bus.prog_opcode;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    bank_d   = bank_q;
    layer_d  = layer_q;
    nb_d     = nb_q;
    wd_d     = wd_q;
    err_d    = err_q;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          if (nb_ok) begin
            err_d   = 1'b0;
            code_d  = 2'b00;
            layer_d = '0;
            bank_d  = 1'b0;
            nb_d    = bus.nb_layers;
            state_d = S_CFG;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b11;
          end
        end
      end
      S_CFG: begin
        opcode_d = table_q[layer_q];
        state_d  = S_ARM;
      end
      S_ARM:   state_d = S_START;
      S_START: begin
        wd_d    = bus.to_limit;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A zero watchdog count means the watchdog is disabled for this layer.
        if (done_edge) begin
          state_d = S_NEXT;
        end else if (wd_q != '0) begin
          if (wd_q == TO_W'(1)) begin
            state_d = S_HALT;
            err_d   = 1'b1;
            code_d  = 2'b01;
          end else begin
            wd_d = wd_q - 1'b1;
          end
        end
      end
      S_NEXT: begin
        bank_d = ~bank_q;
        if (last_layer) begin
          state_d = S_FIN;
        end else begin
          layer_d = layer_q + 1'b1;
          state_d = S_CFG;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_HALT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort pre-empts whatever else this cycle would have done.
    if (bus.abort && state_q != S_IDLE && state_q != S_HALT) begin
      state_d  = S_HALT;
      opcode_d = opcode_q;
      bank_d   = bank_q;
      layer_d  = layer_q;
      err_d    = 1'b1;
      code_d   = 2'b10;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      bank_q   <= 1'b0;
      layer_q  <= '0;
      nb_q     <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      bank_q   <= bank_d;
      layer_q  <= layer_d;
      nb_q     <= nb_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      code_q   <= code_d;
      done_q   <= bus.fsm_done;
    end
  end

  assign bus.npu_opcode = opcode_q;
  assign bus.npu_rst    = rst | (state_q == S_CFG) | (state_q == S_HALT);
  assign bus.npu_start  = (state_q == S_START);
  assign bus.bank_sel   = bank_q;
  assign bus.cur_layer  = layer_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.seq_done   = (state_q == S_FIN);
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_npu_layer_seq.sv
// Self-checking bench for npu_layer_seq: a behavioural layer-fsm model answers npu_start,
// and each scenario is compared against expectations derived from the program table.
module tb_npu_layer_seq;
  localparam int ML  = 8;
  localparam int CL  = 3;
  localparam int OPW = 3;
  localparam int TW  = 16;

  logic ck = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  npu_layer_seq_if #(.CLOG2ML(CL), .OPW(OPW), .TO_W(TW)) bus ();

  npu_layer_seq #(.MAX_LAYERS(ML), .CLOG2ML(CL), .OPW(OPW), .TO_W(TW)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- layer fsm model ----------------
  // mode 0: done rises fsm_delay cycles after start, cleared by npu_rst
  // mode 1: done stays high across npu_rst/CFG/ARM/START/first RUN cycle
  // mode 2: done never rises
  int fsm_mode    = 0;
  int fsm_delay   = 10;
  int abort_layer = -1;
  int fcnt        = 0;

  always @(posedge ck) begin
    #1;
    bus.abort = 1'b0;
    if (rst) begin
      fcnt = 0;
      bus.fsm_done = 1'b0;
    end else if (bus.npu_rst && fsm_mode != 1) begin
      fcnt = 0;
      bus.fsm_done = 1'b0;
    end else if (bus.npu_start) begin
      fcnt = fsm_delay;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0 && fsm_mode != 2) begin
        bus.fsm_done = 1'b1;
        if (abort_layer >= 0 && int'(bus.cur_layer) == abort_layer) bus.abort = 1'b1;
      end else if (fsm_mode != 1 || fcnt <= fsm_delay - 2) begin
        bus.fsm_done = 1'b0;
      end
    end else if (fsm_mode == 1 && !bus.busy) begin
      bus.fsm_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  logic [OPW-1:0] ref_tbl [ML];

  int             st_cyc   [$];
  logic [OPW-1:0] st_op    [$];
  logic           st_bank  [$];
  logic [CL-1:0]  st_layer [$];
  int sd_cnt, sd_cyc, rst_first, rst_last, end_cyc, t_run;
  bit hung;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic write_tbl(input int addr, input logic [OPW-1:0] val);
    bus.prog_we     = 1'b1;
    bus.prog_addr   = addr[CL-1:0];
    bus.prog_opcode = val;
    ref_tbl[addr]   = val;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < ML; i++) write_tbl(i, OPW'($urandom_range(0, 7)));
  endtask

  // Launches one run request and records the observable behaviour until busy drops.
  task automatic run_seq(input int nb, input int lim, input int busy_wr,
                         input logic [OPW-1:0] busy_val, input bit wr_with_run,
                         input logic [OPW-1:0] wr_val);
    bit fin;
    st_cyc.delete(); st_op.delete(); st_bank.delete(); st_layer.delete();
    sd_cnt = 0; sd_cyc = -1; rst_first = -1; rst_last = -1; end_cyc = -1; fin = 0;
    bus.nb_layers = nb[CL:0];
    bus.to_limit  = lim[TW-1:0];
    bus.run       = 1'b1;
    if (wr_with_run) begin
      bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_opcode = wr_val;
    end
    t_run = cyc;
    tick();
    bus.run = 1'b0;
    bus.prog_we = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (bus.npu_start) begin
        st_cyc.push_back(cyc); st_op.push_back(bus.npu_opcode);
        st_bank.push_back(bus.bank_sel); st_layer.push_back(bus.cur_layer);
      end
      if (bus.seq_done) begin sd_cnt++; sd_cyc = cyc; end
      if (bus.npu_rst) begin
        if (rst_first < 0) rst_first = cyc;
        rst_last = cyc;
      end
      if (!bus.busy) begin end_cyc = cyc; fin = 1; break; end
      if (busy_wr >= 0 && k == 2) begin
        bus.prog_we = 1'b1; bus.prog_addr = busy_wr[CL-1:0]; bus.prog_opcode = busy_val;
      end else begin
        bus.prog_we = 1'b0;
      end
      tick();
    end
    bus.prog_we = 1'b0;
    hung = !fin;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    n_checks++; if (bus.npu_rst !== 1'b1) begin n_errors++; $display("FAIL rst_npu_rst: got %b exp 1", bus.npu_rst); end
    n_checks++; if (bus.npu_start !== 1'b0) begin n_errors++; $display("FAIL rst_start: got %b exp 0", bus.npu_start); end
    n_checks++; if (bus.npu_opcode !== 3'd0) begin n_errors++; $display("FAIL rst_opcode: got %0d exp 0", bus.npu_opcode); end
    n_checks++; if (bus.bank_sel !== 1'b0) begin n_errors++; $display("FAIL rst_bank: got %b exp 0", bus.bank_sel); end
    n_checks++; if (bus.cur_layer !== 3'd0) begin n_errors++; $display("FAIL rst_layer: got %0d exp 0", bus.cur_layer); end
    n_checks++; if (bus.seq_done !== 1'b0) begin n_errors++; $display("FAIL rst_seq_done: got %b exp 0", bus.seq_done); end
    n_checks++; if ({bus.err, bus.err_code} !== 3'b000) begin n_errors++; $display("FAIL rst_err: got %b exp 000", {bus.err, bus.err_code}); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.npu_rst !== 1'b0) begin n_errors++; $display("FAIL rst_release: got %b exp 0", bus.npu_rst); end
  endtask

  // Full sequence against a timing/outcome model derived from the program table.
  task automatic test_sequence(input string name, input int nb, input int lim,
                               input int delay, input int ab);
    bit to_hit, ab_hit, ok;
    int n_exp, e_end, e_layer;
    logic e_bank;
    logic [1:0] e_code;
    fsm_mode = 0; fsm_delay = delay; abort_layer = ab;
    run_seq(nb, lim, -1, '0, 1'b0, '0);
    abort_layer = -1;
    to_hit = (lim != 0 && delay > lim);
    ab_hit = !to_hit && ab >= 0 && ab < nb;
    ok     = !to_hit && !ab_hit;
    n_exp  = to_hit ? 1 : (ab_hit ? ab + 1 : nb);
    if (ok) begin
      e_end = t_run + 3 + (nb - 1) * (delay + 4) + delay + 3;
      e_bank = nb[0]; e_layer = nb - 1; e_code = 2'b00;
    end else if (to_hit) begin
      e_end = t_run + 3 + lim + 2; e_bank = 1'b0; e_layer = 0; e_code = 2'b01;
    end else begin
      e_end = t_run + 3 + ab * (delay + 4) + delay + 2;
      e_bank = ab[0]; e_layer = ab; e_code = 2'b10;
    end
    n_checks++; if (hung !== 1'b0) begin n_errors++; $display("FAIL %s_hung: busy never dropped", name); end
    n_checks++; if (st_cyc.size() !== n_exp) begin n_errors++; $display("FAIL %s_nstart: got %0d exp %0d", name, st_cyc.size(), n_exp); end
    for (int i = 0; i < st_cyc.size() && i < n_exp; i++) begin
      n_checks++;
      if (st_cyc[i] !== t_run + 3 + i * (delay + 4) || st_op[i] !== ref_tbl[i] ||
          st_bank[i] !== i[0] || st_layer[i] !== i[CL-1:0]) begin
        n_errors++;
        $display("FAIL %s_start%0d: got cyc %0d op %0d bank %b layer %0d exp cyc %0d op %0d bank %b layer %0d",
                 name, i, st_cyc[i] - t_run, st_op[i], st_bank[i], st_layer[i],
                 3 + i * (delay + 4), ref_tbl[i], i[0], i);
      end
    end
    n_checks++; if (rst_first !== t_run + 1) begin n_errors++; $display("FAIL %s_rst_lat: got %0d exp 1", name, rst_first - t_run); end
    n_checks++; if (sd_cnt !== int'(ok)) begin n_errors++; $display("FAIL %s_seq_done: got %0d exp %0d", name, sd_cnt, int'(ok)); end
    n_checks++; if (end_cyc !== e_end) begin n_errors++; $display("FAIL %s_end: got %0d exp %0d", name, end_cyc - t_run, e_end - t_run); end
    n_checks++;
    if (bus.err !== !ok || bus.err_code !== e_code || bus.bank_sel !== e_bank ||
        int'(bus.cur_layer) !== e_layer || bus.npu_opcode !== ref_tbl[e_layer]) begin
      n_errors++;
      $display("FAIL %s_final: got err %b code %b bank %b layer %0d op %0d exp err %b code %b bank %b layer %0d op %0d",
               name, bus.err, bus.err_code, bus.bank_sel, bus.cur_layer, bus.npu_opcode,
               !ok, e_code, e_bank, e_layer, ref_tbl[e_layer]);
    end
  endtask

  task automatic test_two_layer();
    write_tbl(0, 3'b000);
    write_tbl(1, 3'b001);
    test_sequence("two_layer", 2, 0, 10, -1);
  endtask

  task automatic test_timeout();
    fsm_mode = 2; fsm_delay = 3;
    run_seq(1, 5, -1, '0, 1'b0, '0);
    fsm_mode = 0;
    n_checks++; if (st_cyc.size() !== 1) begin n_errors++; $display("FAIL to_nstart: got %0d exp 1", st_cyc.size()); end
    n_checks++; if (rst_last !== t_run + 9) begin n_errors++; $display("FAIL to_halt_rst: got %0d exp 9", rst_last - t_run); end
    n_checks++; if (end_cyc !== t_run + 10) begin n_errors++; $display("FAIL to_end: got %0d exp 10", end_cyc - t_run); end
    n_checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b01) begin n_errors++; $display("FAIL to_err: got %b%b exp 101", bus.err, bus.err_code); end
    n_checks++; if (sd_cnt !== 0) begin n_errors++; $display("FAIL to_seq_done: got %0d exp 0", sd_cnt); end
  endtask

  task automatic test_bad_nb();
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        fsm_mode = 0; fsm_delay = 3;
        run_seq(1, 0, -1, '0, 1'b0, '0);
        n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL badnb_clear: got %b exp 0", bus.err); end
      end
      run_seq(pass == 0 ? 0 : 9, 0, -1, '0, 1'b0, '0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (bus.busy || bus.npu_rst || bus.npu_start) bad++;
        tick();
      end
      n_checks++; if (bad + st_cyc.size() !== 0 || rst_first !== -1) begin n_errors++; $display("FAIL badnb%0d_activity: got %0d active cycles exp 0", pass, bad + st_cyc.size()); end
      n_checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b11) begin n_errors++; $display("FAIL badnb%0d_err: got %b%b exp 111", pass, bus.err, bus.err_code); end
    end
  endtask

  task automatic test_hold_done();
    fsm_mode = 1; fsm_delay = 6;
    tick(); tick();
    run_seq(3, 0, -1, '0, 1'b0, '0);
    fsm_mode = 0;
    n_checks++; if (st_cyc.size() !== 3) begin n_errors++; $display("FAIL hold_nstart: got %0d exp 3", st_cyc.size()); end
    n_checks++; if (st_cyc.size() == 3 && st_cyc[2] !== t_run + 3 + 2 * 10) begin n_errors++; $display("FAIL hold_start2: got %0d exp 23", st_cyc[2] - t_run); end
    n_checks++; if (end_cyc !== t_run + 3 + 20 + 6 + 3) begin n_errors++; $display("FAIL hold_end: got %0d exp 32", end_cyc - t_run); end
  endtask

  task automatic test_rst_mid_run();
    int n_st, bad;
    bit found;
    write_tbl(1, 3'b101);
    fsm_mode = 0; fsm_delay = 20;
    bus.nb_layers = 4'd3; bus.to_limit = '0; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    n_st = 0; found = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.npu_start) n_st++;
      if (n_st == 2) begin found = 1; break; end
      tick();
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rmr_second_start: got %0d starts exp 2", n_st); end
    tick(); tick();
    n_checks++; if (bus.bank_sel !== 1'b1 || bus.cur_layer !== 3'd1 || bus.npu_opcode !== 3'b101) begin n_errors++; $display("FAIL rmr_pre: got bank %b layer %0d op %0d exp 1 1 5", bus.bank_sel, bus.cur_layer, bus.npu_opcode); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.npu_rst !== 1'b1) begin n_errors++; $display("FAIL rmr_npu_rst: got %b exp 1", bus.npu_rst); end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.npu_start !== 1'b0 || bus.npu_opcode !== 3'd0 || bus.bank_sel !== 1'b0 ||
        bus.cur_layer !== 3'd0 || bus.seq_done !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'b00 ||
        bus.npu_rst !== 1'b1) begin
      n_errors++;
      $display("FAIL rmr_reset_vals: got busy %b start %b op %0d bank %b layer %0d done %b err %b%b nrst %b",
               bus.busy, bus.npu_start, bus.npu_opcode, bus.bank_sel, bus.cur_layer,
               bus.seq_done, bus.err, bus.err_code, bus.npu_rst);
    end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.npu_start || bus.seq_done || bus.busy) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rmr_quiet: got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_prog_we_busy();
    write_tbl(0, 3'b010);
    fsm_mode = 0; fsm_delay = 4;
    run_seq(1, 0, 0, 3'b111, 1'b0, '0);
    run_seq(1, 0, -1, '0, 1'b0, '0);
    n_checks++; if (st_op.size() !== 1 || st_op[0] !== 3'b010) begin n_errors++; $display("FAIL we_busy: got %0d exp 2", st_op.size() > 0 ? st_op[0] : 3'bxxx); end
  endtask

  task automatic test_write_with_run();
    fsm_mode = 0; fsm_delay = 4;
    ref_tbl[0] = 3'b110;
    run_seq(1, 0, -1, '0, 1'b1, 3'b110);
    n_checks++; if (st_op.size() !== 1 || st_op[0] !== 3'b110) begin n_errors++; $display("FAIL wr_with_run: got %0d exp 6", st_op.size() > 0 ? st_op[0] : 3'bxxx); end
  endtask

  task automatic test_random();
    int nb, lim, dly, ab;
    for (int it = 0; it < 10; it++) begin
      load_table();
      nb  = $urandom_range(1, ML);
      dly = $urandom_range(1, 12);
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 14);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      test_sequence($sformatf("rand%0d", it), nb, lim, dly, ab);
      tick();
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_opcode = '0;
    bus.run = 1'b0; bus.nb_layers = '0; bus.to_limit = '0;
    test_reset();
    test_two_layer();
    test_timeout();
    test_sequence("to_edge_last", 1, 5, 5, -1);
    test_sequence("to_edge_late", 1, 5, 6, -1);
    load_table();
    test_sequence("abort_l0", 3, 0, 7, 0);
    test_bad_nb();
    test_hold_done();
    test_rst_mid_run();
    test_prog_we_busy();
    test_write_with_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
